// File: rtl/rbm_layer_sequencer.sv
// Time-multiplexed control sequencer for the RBM inference datapath: one shared MAC,
// weight port, sampler and class accumulator, stepped unit by unit over ITERATIONS passes.
module rbm_layer_sequencer #(
    parameter int IN_DIM     = 15,
    parameter int H_DIM      = 5,
    parameter int OUT_DIM    = 2,
    parameter int ITERATIONS = 10,
    parameter int ADDR_W     = 7,
    parameter int IDX_W      = 4,
    parameter int UNIT_W     = 3,
    parameter int ITER_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              layer_sel,
    output logic              rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [IDX_W-1:0]  in_idx,
    output logic [UNIT_W-1:0] unit_idx,
    output logic              mac_clear,
    output logic              mac_en,
    output logic              bias_en,
    output logic              sample_en,
    output logic              acc_en,
    output logic              acc_clear,
    output logic              rng_step,
    output logic [ITER_W-1:0] iter_num
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_ITER,
        S_CLR,
        S_MAC,
        S_DRAIN,
        S_BIAS,
        S_SAMPLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [UNIT_W-1:0] unit, unit_nx;
    logic [ITER_W-1:0] iter, iter_nx;
    logic              layer, layer_nx;
    logic              mac_q;
    logic [IDX_W-1:0]  last_idx;
    logic              run;

    // hold freezes every register, including the one-cycle read-latency delay for mac_en
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            unit  <= '0;
            iter  <= '0;
            layer <= 1'b0;
            mac_q <= 1'b0;
        end else if (!hold) begin
            state <= state_nx;
            idx   <= idx_nx;
            unit  <= unit_nx;
            iter  <= iter_nx;
            layer <= layer_nx;
            mac_q <= (state == S_MAC);
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        unit_nx   = unit;
        iter_nx   = iter;
        layer_nx  = layer;
        run       = !hold;
        last_idx  = layer ? IDX_W'(H_DIM - 1) : IDX_W'(IN_DIM - 1);

        busy      = (state != S_IDLE);
        done      = run && (state == S_DONE);
        rd_en     = run && (state == S_MAC);
        mac_en    = run && mac_q;
        mac_clear = run && (state == S_CLR);
        bias_en   = run && (state == S_BIAS);
        sample_en = run && (state == S_SAMPLE);
        acc_en    = run && (state == S_ACC);
        acc_clear = run && (state == S_INIT);
        rng_step  = run && (state == S_ITER);
        layer_sel = layer;
        in_idx    = idx;
        unit_idx  = unit;
        iter_num  = iter;
        w_addr    = layer ? ADDR_W'(idx) * ADDR_W'(OUT_DIM) + ADDR_W'(unit)
                          : ADDR_W'(idx) * ADDR_W'(H_DIM) + ADDR_W'(unit);

        case (state)
            S_IDLE:   if (start) state_nx = S_INIT;
            S_INIT: begin
                iter_nx  = '0;
                state_nx = S_ITER;
            end
            S_ITER: begin
                unit_nx  = '0;
                layer_nx = 1'b0;
                state_nx = S_CLR;
            end
            S_CLR: begin
                idx_nx   = '0;
                state_nx = S_MAC;
            end
            S_MAC: begin
                if (idx == last_idx) state_nx = S_DRAIN;
                else                 idx_nx   = idx + 1'b1;
            end
            S_DRAIN:  state_nx = S_BIAS;
            S_BIAS:   state_nx = layer ? S_ACC : S_SAMPLE;
            S_SAMPLE: begin
                if (unit == UNIT_W'(H_DIM - 1)) begin
                    unit_nx  = '0;
                    layer_nx = 1'b1;
                end else begin
                    unit_nx  = unit + 1'b1;
                end
                state_nx = S_CLR;
            end
            S_ACC: begin
                if (unit == UNIT_W'(OUT_DIM - 1)) begin
                    iter_nx  = iter + 1'b1;
                    state_nx = (iter_nx == ITER_W'(ITERATIONS)) ? S_DONE : S_ITER;
                end else begin
                    unit_nx  = unit + 1'b1;
                    state_nx = S_CLR;
                end
            end
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rbm_layer_sequencer.sv
// Scoreboard bench for rbm_layer_sequencer: expected read transactions and unit events
// are queued per run and consumed as the sequencer emits them.
module tb_rbm_layer_sequencer;

    localparam int IN_DIM     = 15;
    localparam int H_DIM      = 5;
    localparam int OUT_DIM    = 2;
    localparam int ITERATIONS = 10;
    localparam int ADDR_W     = 7;
    localparam int IDX_W      = 4;
    localparam int UNIT_W     = 3;
    localparam int ITER_W     = 8;
    localparam int RUN_CYC    = 1 + ITERATIONS * (1 + H_DIM * (IN_DIM + 4) + OUT_DIM * (H_DIM + 4)) + 1;

    logic              clock = 1'b0;
    logic              reset, start, hold;
    logic              busy, done, layer_sel, rd_en;
    logic [ADDR_W-1:0] w_addr;
    logic [IDX_W-1:0]  in_idx;
    logic [UNIT_W-1:0] unit_idx;
    logic              mac_clear, mac_en, bias_en, sample_en, acc_en, acc_clear, rng_step;
    logic [ITER_W-1:0] iter_num;

    rbm_layer_sequencer #(
        .IN_DIM(IN_DIM), .H_DIM(H_DIM), .OUT_DIM(OUT_DIM), .ITERATIONS(ITERATIONS),
        .ADDR_W(ADDR_W), .IDX_W(IDX_W), .UNIT_W(UNIT_W), .ITER_W(ITER_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .hold(hold),
        .busy(busy), .done(done), .layer_sel(layer_sel), .rd_en(rd_en),
        .w_addr(w_addr), .in_idx(in_idx), .unit_idx(unit_idx),
        .mac_clear(mac_clear), .mac_en(mac_en), .bias_en(bias_en),
        .sample_en(sample_en), .acc_en(acc_en), .acc_clear(acc_clear),
        .rng_step(rng_step), .iter_num(iter_num)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;
    int ecount = 0, e0 = 0;
    int n_busy, n_done, done_cyc, n_rng, n_acc, n_accclr, accclr_first, accclr_last;
    int mac_err, hold_err;
    logic prev_rd = 1'b0, prev_hold = 1'b0;
    logic [ADDR_W+IDX_W+UNIT_W-1:0] frz;
    logic [ITER_W+1+UNIT_W+IDX_W+ADDR_W-1:0] rdq[$];
    logic [1+1+UNIT_W:0] evq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    always @(posedge clock) ecount <= ecount + 1;

    always @(negedge clock) begin
        int cyc;
        logic [ITER_W+1+UNIT_W+IDX_W+ADDR_W-1:0] e_rd;
        logic [1+1+UNIT_W:0] e_ev;
        logic [1:0] kind;
        cyc = ecount - e0;
        if (reset) begin
            prev_rd   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (busy)     n_busy++;
            if (done)     begin n_done++; done_cyc = cyc; end
            if (rng_step) n_rng++;
            if (acc_en)   n_acc++;
            if (acc_clear) begin
                if (n_accclr == 0) accclr_first = cyc;
                accclr_last = cyc;
                n_accclr++;
            end
            if (mac_en !== (prev_rd && !hold)) mac_err++;
            if (!hold) prev_rd = rd_en;
            if (hold) begin
                if (!prev_hold) frz = {w_addr, in_idx, unit_idx};
                else if ({w_addr, in_idx, unit_idx} !== frz) hold_err++;
                if (rd_en | mac_en | mac_clear | bias_en | sample_en | acc_en |
                    acc_clear | rng_step | done) hold_err++;
            end
            prev_hold = hold;
            if (rd_en) begin
                if (rdq.size() == 0) chk("rd_extra", 64'd1, 64'd0);
                else begin
                    e_rd = rdq.pop_front();
                    chk("rd_txn", {iter_num, layer_sel, unit_idx, in_idx, w_addr}, e_rd);
                end
            end
            if (bias_en | sample_en | acc_en) begin
                kind = bias_en ? 2'd1 : (sample_en ? 2'd2 : 2'd3);
                if (evq.size() == 0) chk("ev_extra", 64'd1, 64'd0);
                else begin
                    e_ev = evq.pop_front();
                    chk("unit_ev", {kind, layer_sel, unit_idx}, e_ev);
                end
            end
        end
    end

    task automatic push_run();
        rdq.delete();
        evq.delete();
        for (int it = 0; it < ITERATIONS; it++) begin
            for (int u = 0; u < H_DIM; u++) begin
                for (int i = 0; i < IN_DIM; i++)
                    rdq.push_back({ITER_W'(it), 1'b0, UNIT_W'(u), IDX_W'(i), ADDR_W'(i * H_DIM + u)});
                evq.push_back({2'd1, 1'b0, UNIT_W'(u)});
                evq.push_back({2'd2, 1'b0, UNIT_W'(u)});
            end
            for (int u = 0; u < OUT_DIM; u++) begin
                for (int i = 0; i < H_DIM; i++)
                    rdq.push_back({ITER_W'(it), 1'b1, UNIT_W'(u), IDX_W'(i), ADDR_W'(i * OUT_DIM + u)});
                evq.push_back({2'd1, 1'b1, UNIT_W'(u)});
                evq.push_back({2'd3, 1'b1, UNIT_W'(u)});
            end
        end
    endtask

    task automatic begin_run(input logic keep_start);
        push_run();
        @(negedge clock);
        n_busy = 0; n_done = 0; done_cyc = -1; n_rng = 0; n_acc = 0;
        n_accclr = 0; accclr_first = -1; accclr_last = -1; mac_err = 0; hold_err = 0;
        start = 1'b1;
        @(posedge clock);
        #1;
        e0 = ecount - 1;
        if (!keep_start) start = 1'b0;
    endtask

    task automatic goto_cycle(input int n);
        while (ecount - e0 < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (n_done == 0 && k < limit) begin
            @(posedge clock);
            k++;
        end
        chk("done_seen", 64'(n_done != 0), 64'd1);
    endtask

    task automatic end_checks(input int exp_done);
        repeat (3) @(posedge clock);
        #1;
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("done_count", 64'(n_done), 64'd1);
        chk("busy_cycles", 64'(n_busy), 64'(exp_done));
        chk("rng_steps", 64'(n_rng), 64'(ITERATIONS));
        chk("acc_pulses", 64'(n_acc), 64'(ITERATIONS * OUT_DIM));
        chk("acc_clear_cyc", 64'(accclr_first), 64'd1);
        chk("acc_clear_cnt", 64'(n_accclr), 64'd1);
        chk("rdq_left", 64'(rdq.size()), 64'd0);
        chk("evq_left", 64'(evq.size()), 64'd0);
        chk("mac_follow", 64'(mac_err), 64'd0);
        chk("hold_quiet", 64'(hold_err), 64'd0);
        chk("iter_final", 64'(iter_num), 64'(ITERATIONS));
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, layer_sel, rd_en, w_addr, in_idx, unit_idx, mac_clear, mac_en,
                    bias_en, sample_en, acc_en, acc_clear, rng_step, iter_num});
    endfunction

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic busy_seen;
        reset = 1'b1; start = 1'b0; hold = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outs", all_outs(), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // nominal run
        begin_run(1'b0);
        wait_done(RUN_CYC + 50);
        end_checks(RUN_CYC);

        // seven held cycles inside hidden unit 1's MAC phase
        begin_run(1'b0);
        goto_cycle(30);
        chk("hold_in_mac", 64'({dut.state == dut.S_MAC, unit_idx}), 64'({1'b1, 3'd1}));
        hold = 1'b1;
        goto_cycle(37);
        hold = 1'b0;
        wait_done(RUN_CYC + 60);
        end_checks(RUN_CYC + 7);

        // hold in IDLE blocks start
        @(negedge clock);
        hold = 1'b1; start = 1'b1; busy_seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            busy_seen = busy_seen | busy;
        end
        start = 1'b0; hold = 1'b0;
        chk("idle_hold_start", 64'(busy_seen), 64'd0);
        repeat (2) @(negedge clock);

        // reset mid-run, then a clean rerun
        begin_run(1'b0);
        goto_cycle(500);
        reset = 1'b1;
        #1;
        chk("abort_outs", all_outs(), 64'd0);
        chk("abort_no_done", 64'(n_done), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("abort_still_no_done", 64'(n_done), 64'd0);
        repeat (2) @(negedge clock);
        begin_run(1'b0);
        wait_done(RUN_CYC + 50);
        end_checks(RUN_CYC);

        // start held high across a whole run
        begin_run(1'b1);
        wait_done(RUN_CYC + 50);
        chk("cont_done_cyc", 64'(done_cyc), 64'(RUN_CYC));
        begin
            int k = 0;
            while (n_accclr < 2 && k < 20) begin
                @(posedge clock);
                k++;
            end
        end
        #1;
        chk("cont_clears", 64'(n_accclr), 64'd2);
        chk("cont_reinit_cyc", 64'(accclr_last), 64'(RUN_CYC + 2));
        chk("cont_done_once", 64'(n_done), 64'd1);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rbm_layer_sequencer.md
Name: rbm_layer_sequencer

Overview:
Time-multiplexed sequencer for the RBM inference datapath. It replaces the fully parallel hidden/class evaluation with a single shared MAC, weight-memory read port, sigmoid/sampler and class accumulator. For each of ITERATIONS stochastic passes, it drives weight addresses, MAC strobes, hidden-unit sampling and class-output accumulation in a fixed order. It then signals completion, playing the role of `finish` for the cumulated result.

Parameters:
IN_DIM, 15, visible (image) units
H_DIM, 5, hidden units
OUT_DIM, 2, class units
ITERATIONS, 10, sampling passes per run (>=1)
ADDR_W, 7, weight address width (holds IN_DIM*H_DIM-1)
IDX_W, 4, input index width (holds max(IN_DIM,H_DIM)-1)
UNIT_W, 3, unit index width (holds max(H_DIM,OUT_DIM)-1)
ITER_W, 8, iteration counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
start  in  1  run request, sampled in IDLE only
hold   in  1  stall; freezes sequencer and suppresses all strobes
busy   out  1  high in every state except IDLE
done   out  1  one-cycle pulse in DONE state
layer_sel  out  1  0 = hidden layer, 1 = class layer
rd_en  out  1  weight/input read strobe
w_addr  out  ADDR_W  weight address: hidden idx*H_DIM+unit, class idx*OUT_DIM+unit
in_idx  out  IDX_W  input operand index (visible unit, or hidden sample in class layer)
unit_idx  out  UNIT_W  unit currently being evaluated
mac_clear  out  1  zero the MAC accumulator
mac_en  out  1  accumulate product; rd_en delayed one cycle (memory latency 1)
bias_en  out  1  add bias[unit_idx] to MAC
sample_en  out  1  sigmoid-compare MAC vs RNG and latch hidden bit unit_idx
acc_en  out  1  add class MAC result into cumulated Result[unit_idx]
acc_clear  out  1  zero all cumulated results
rng_step  out  1  advance RNG seeds once per iteration
iter_num  out  ITER_W  current iteration, 0-based

Behaviour:
- Reset (async): state IDLE; all strobes, busy, done = 0; w_addr, in_idx, unit_idx, iter_num, layer_sel = 0; mac_en delay register = 0.
- Strobes are Moore decodes of registered state. mac_en is a registered copy of rd_en.
- States and transitions:
  - IDLE: start=1 -> INIT. start while busy is ignored.
  - INIT (acc_clear=1, iter=0) -> ITER.
  - ITER (rng_step=1, unit=0, layer_sel=0) -> CLR.
  - CLR (mac_clear=1, idx=0) -> MAC.
  - MAC: rd_en=1, in_idx=idx. Stays for N cycles, where N = IN_DIM (hidden) or H_DIM (class). idx increments each cycle. After last idx -> DRAIN.
  - DRAIN: no rd_en; mac_en=1 for the last operand -> BIAS.
  - BIAS (bias_en=1) -> SAMPLE (hidden) or ACC (class).
  - SAMPLE (sample_en=1):
    - unit<H_DIM-1: unit++, -> CLR.
    - else: unit=0, layer_sel=1, -> CLR.
  - ACC (acc_en=1):
    - unit<OUT_DIM-1: unit++, -> CLR.
    - else: iter++; iter==ITERATIONS -> DONE, else -> ITER.
  - DONE (done=1, busy=1) -> IDLE. iter_num keeps final value until next INIT.
- Per-unit cost: N+4 cycles.
- Per-iteration cost: 1 + H_DIM*(IN_DIM+4) + OUT_DIM*(H_DIM+4) = 114 at defaults.
- Run length: start accepted at edge 0; INIT in cycle 1; DONE in cycle 1 + ITERATIONS*114 = 1141 + 1 = cycle 1142; IDLE at 1143.
- hold=1:
  - State, counters and the mac_en delay register freeze.
  - All strobe outputs forced 0; done pulse is deferred, not lost.
  - Address/index outputs hold their values.
  - Datapath memory holds its output while rd_en=0.
  - Deassert resumes exactly where frozen; total cycles = nominal + held cycles.
- hold in IDLE: start still ignored until hold=0.
- Reset mid-run: immediate return to IDLE with no done pulse. Next start re-runs from INIT, including acc_clear.
- Counters never wrap within a run. ITER_W must cover ITERATIONS.

Test Plan:
- Defaults, start pulse at cycle 0 -> acc_clear at cycle 1; done single pulse at cycle 1142; busy high cycles 1-1142; exactly 10 rng_step and 20 acc_en pulses.
- Hidden unit 2, iteration 0 -> w_addr sequence 2,7,12,...,72 (15 values); mac_en follows rd_en by 1 cycle; bias_en then sample_en with unit_idx=2.
- Class unit 1 -> w_addr 1,3,5,7,9, in_idx 0-4, layer_sel=1, then bias_en then acc_en with unit_idx=1.
- hold high for 7 cycles mid-MAC -> no strobes during hold, addresses frozen, done at cycle 1149; MAC products identical to unheld run.
- reset asserted at cycle 500 -> all outputs 0 asynchronously, no done. Restart -> fresh 1142-cycle run with acc_clear.
- start held high continuously -> second run begins at cycle 1143 (IDLE), INIT at 1144; start pulses while busy produce no effect.
